mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32: address width in bits for every port.
REQ-002 The block SHALL take parameter LINE_W, default 256: data width in bits for every port.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 i_read  in  1  instruction-side read request; held until i_resp.
REQ-006 i_address  in  ADDR_W  instruction-side line address.
REQ-007 i_rdata  out  LINE_W  instruction-side read data; valid only while i_resp=1.
REQ-008 i_resp  out  1  instruction-side one-cycle completion pulse.
REQ-009 d_read  in  1  data-side read request; held until d_resp.
REQ-010 d_write  in  1  data-side write request; held until d_resp.
REQ-011 d_address  in  ADDR_W  data-side line address.
REQ-012 d_wdata  in  LINE_W  data-side write data.
REQ-013 d_rdata  out  LINE_W  data-side read data; valid only while d_resp=1.
REQ-014 d_resp  out  1  data-side one-cycle completion pulse.
REQ-015 mem_read  out  1  shared memory read strobe; level, held until mem_resp.
REQ-016 mem_write  out  1  shared memory write strobe; level, held until mem_resp.
REQ-017 mem_address  out  ADDR_W  shared memory address.
REQ-018 mem_wdata  out  LINE_W  shared memory write data.
REQ-019 mem_rdata  in  LINE_W  shared memory read data; valid when mem_resp=1.
REQ-020 mem_resp  in  1  shared memory completion; may arrive any number of cycles (>=1) after a strobe is raised.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-022 IDLE, i_read=1 only: next state SERVE_I.
REQ-023 IDLE, (d_read|d_write)=1 only: next state SERVE_D.
REQ-024 IDLE, both sides requesting: grant the side not recorded in last_grant; last_grant updated on every grant.
REQ-025 IDLE, no request: stay IDLE; mem_read=mem_write=0.
REQ-026 On the grant edge the block SHALL latch address, wdata and opcode of the granted side into internal registers; mem_address, mem_wdata, mem_read and mem_write are driven only from these registers.
REQ-027 Requester input changes after the grant edge SHALL NOT affect the in-flight memory transaction.
REQ-028 d_read and d_write both high at grant: latch as write (mem_write=1, mem_read=0).
REQ-029 SERVE_x with mem_resp=0: hold state and all mem_* outputs constant.
REQ-030 SERVE_x with mem_resp=1: same cycle, assert x_resp=1 and drive x_rdata=mem_rdata combinationally; next state IDLE; mem strobes 0 from the next cycle.
REQ-031 The non-granted side's resp SHALL remain 0 throughout; its rdata is don't-care.
REQ-032 After every completion the block SHALL spend at least one cycle in IDLE before the next grant, so a requester that drops its request on resp is not re-granted.
REQ-033 mem_resp received in IDLE SHALL be ignored: no resp pulse, no state change.
REQ-034 Latency: request seen in IDLE at cycle N gives the strobe from cycle N+1; x_resp fires in the same cycle as mem_resp.
REQ-035 mem_read and mem_write SHALL never be 1 at the same time.
REQ-036 At most one of i_resp and d_resp SHALL be 1 in any cycle.

Reset
REQ-037 reset=1 at a posedge: state<=IDLE, last_grant<=D (the instruction side wins the first tie), latched address/wdata<=0, opcode<=none.
REQ-038 While reset is asserted and on the first cycle after it: mem_read=mem_write=0, i_resp=d_resp=0.
REQ-039 reset during SERVE_x SHALL abandon the transaction: no x_resp pulse, and any later mem_resp is ignored per REQ-033.

Verification
REQ-040 Single fetch: i_read=1, i_address=0x0000_0060, mem_resp after 3 cycles with mem_rdata=0xA5..A5 -> mem_read=1 and mem_address=0x60 from the next cycle; i_resp=1 with i_rdata=0xA5..A5 for exactly 1 cycle; d_resp stays 0.
REQ-041 Tie after reset: i_read=1 and d_read=1 in the same cycle -> SERVE_I first; after completion plus one IDLE cycle, SERVE_D; with both held, grants alternate I,D,I,D.
REQ-042 Data write: d_write=1, d_address=0x100, d_wdata=0x1234 (zero-extended) -> mem_write=1, mem_address=0x100, mem_wdata=0x1234; d_resp pulses on mem_resp; mem_read stays 0 throughout.
REQ-043 Input change in flight: change d_address 0x100->0x200 two cycles after grant -> mem_address stays 0x100 until mem_resp.
REQ-044 Reset mid-transaction: reset for 1 cycle during SERVE_D, then mem_resp=1 -> no d_resp; strobes 0; FSM in IDLE; next tie grants I.
REQ-045 Stray response: mem_resp=1 in IDLE with no request -> i_resp=d_resp=0 and state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared line-wide memory port.
// Ties alternate between sides; each grant latches the winner's request until completion.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;

  // Tie goes to whichever side did not win last time
  always_comb begin
    d_req   = d_read | d_write;
    grant_i = i_read & (~d_req | last_grant_d);
    grant_d = d_req & (~i_read | ~last_grant_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state        <= SERVE_I;
            last_grant_d <= 1'b0;
            addr_q       <= i_address;
            wdata_q      <= '0;
            rd_q         <= 1'b1;
            wr_q         <= 1'b0;
          end else if (grant_d) begin
            // A simultaneous read+write is served as a write
            state        <= SERVE_D;
            last_grant_d <= 1'b1;
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
            rd_q         <= ~d_write;
            wr_q         <= d_write;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state <= IDLE;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory side is driven purely from the latched request
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

  // Completion is forwarded in the same cycle as mem_resp; suppressed under reset
  assign i_resp  = ~reset & mem_resp & (state == SERVE_I);
  assign d_resp  = ~reset & mem_resp & (state == SERVE_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of grant order and completion routing.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read   = 1'b0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    mem_resp = 1'b0;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int k = 0; k < int'(LINE_W / 32); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    i_read = 1'b1;
    d_read = 1'b1;
    cyc();
    cyc();
    n_checks++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: rd/wr/iresp/dresp=%b want 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    reset = 1'b0;
    i_read = 1'b0;
    d_read = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000 || mem_address !== '0) begin
      n_fail++;
      $display("FAIL reset_after: rd/wr/iresp/dresp=%b addr=%h want 0000 addr 0",
               {mem_read, mem_write, i_resp, d_resp}, mem_address);
    end
  endtask

  task automatic test_single_fetch();
    i_read = 1'b1;
    i_address = 32'h0000_0060;
    #1;
    n_checks++;
    if (mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_early: mem_read=%b want 0 in request cycle", mem_read);
    end
    cyc();
    n_checks++;
    if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, 32'h60}) begin
      n_fail++;
      $display("FAIL fetch_strobe: rd=%b wr=%b addr=%h want 1 0 60", mem_read, mem_write, mem_address);
    end
    cyc();
    cyc();
    mem_resp = 1'b1;
    mem_rdata = {32{8'hA5}};
    #1;
    n_checks++;
    if ({i_resp, d_resp} !== 2'b10 || i_rdata !== {32{8'hA5}}) begin
      n_fail++;
      $display("FAIL fetch_resp: iresp=%b dresp=%b rdata=%h want 1 0 a5..", i_resp, d_resp, i_rdata);
    end
    cyc();
    i_read = 1'b0;
    mem_resp = 1'b0;
    #1;
    n_checks++;
    if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0000) begin
      n_fail++;
      $display("FAIL fetch_done: iresp/dresp/rd/wr=%b want 0000", {i_resp, d_resp, mem_read, mem_write});
    end
  endtask

  task automatic test_tie_alternate();
    logic              exp_i;
    logic [LINE_W-1:0] rd;
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    i_address = 32'h0000_1000;
    d_address = 32'h0000_2000;
    i_read = 1'b1;
    d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2 == 0);
      cyc();
      n_checks++;
      if (mem_read !== 1'b1 || mem_address !== (exp_i ? 32'h1000 : 32'h2000)) begin
        n_fail++;
        $display("FAIL tie_grant%0d: rd=%b addr=%h want 1 %h", k, mem_read, mem_address,
                 exp_i ? 32'h1000 : 32'h2000);
      end
      repeat ($urandom_range(0, 2)) cyc();
      cyc();
      rd = rand_line();
      mem_resp = 1'b1;
      mem_rdata = rd;
      #1;
      n_checks++;
      if ({i_resp, d_resp} !== {exp_i, ~exp_i} || (exp_i ? i_rdata : d_rdata) !== rd) begin
        n_fail++;
        $display("FAIL tie_resp%0d: iresp=%b dresp=%b want %b %b", k, i_resp, d_resp, exp_i, ~exp_i);
      end
      cyc();
      mem_resp = 1'b0;
      #1;
      n_checks++;
      if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
        n_fail++;
        $display("FAIL tie_gap%0d: rd/wr/iresp/dresp=%b want 0000", k, {mem_read, mem_write, i_resp, d_resp});
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
  endtask

  task automatic test_data_write();
    d_write = 1'b1;
    d_address = 32'h0000_0100;
    d_wdata = LINE_W'(32'h1234);
    cyc();
    n_checks++;
    if ({mem_read, mem_write, mem_address} !== {1'b0, 1'b1, 32'h100} || mem_wdata !== LINE_W'(32'h1234)) begin
      n_fail++;
      $display("FAIL write_strobe: rd=%b wr=%b addr=%h wdata=%h want 0 1 100 1234",
               mem_read, mem_write, mem_address, mem_wdata);
    end
    cyc();
    cyc();
    d_address = 32'h0000_0200;
    d_wdata = rand_line();
    #1;
    n_checks++;
    if (mem_address !== 32'h100 || mem_wdata !== LINE_W'(32'h1234) || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_change: addr=%h wdata=%h rd=%b want 100 1234 0", mem_address, mem_wdata, mem_read);
    end
    cyc();
    mem_resp = 1'b1;
    #1;
    n_checks++;
    if ({d_resp, i_resp, mem_write, mem_read} !== 4'b1010 || mem_address !== 32'h100) begin
      n_fail++;
      $display("FAIL write_resp: dresp/iresp/wr/rd=%b addr=%h want 1010 100",
               {d_resp, i_resp, mem_write, mem_read}, mem_address);
    end
    cyc();
    d_write = 1'b0;
    mem_resp = 1'b0;
    #1;
    n_checks++;
    if ({mem_write, mem_read, d_resp} !== 3'b000) begin
      n_fail++;
      $display("FAIL write_done: wr/rd/dresp=%b want 000", {mem_write, mem_read, d_resp});
    end
  endtask

  task automatic test_rw_collision();
    logic [LINE_W-1:0] wd;
    wd = rand_line();
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 32'h0000_0140;
    d_wdata = wd;
    cyc();
    n_checks++;
    if ({mem_read, mem_write} !== 2'b01 || mem_wdata !== wd || mem_address !== 32'h140) begin
      n_fail++;
      $display("FAIL rw_as_write: rd=%b wr=%b addr=%h want 0 1 140", mem_read, mem_write, mem_address);
    end
    cyc();
    mem_resp = 1'b1;
    #1;
    n_checks++;
    if ({i_resp, d_resp} !== 2'b01) begin
      n_fail++;
      $display("FAIL rw_resp: iresp=%b dresp=%b want 0 1", i_resp, d_resp);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    d_read = 1'b1;
    d_address = 32'h0000_0300;
    cyc();
    n_checks++;
    if ({mem_read, mem_address} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL midrst_grant: rd=%b addr=%h want 1 300", mem_read, mem_address);
    end
    cyc();
    reset = 1'b1;
    d_read = 1'b0;
    mem_resp = 1'b1;
    #1;
    n_checks++;
    if ({i_resp, d_resp} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_during: iresp=%b dresp=%b want 0 0", i_resp, d_resp);
    end
    cyc();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_after: rd/wr/iresp/dresp=%b want 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    cyc();
    mem_resp = 1'b0;
    i_address = 32'h0000_0400;
    d_address = 32'h0000_0500;
    i_read = 1'b1;
    d_read = 1'b1;
    cyc();
    n_checks++;
    if ({mem_read, mem_address} !== {1'b1, 32'h400}) begin
      n_fail++;
      $display("FAIL midrst_tie: rd=%b addr=%h want 1 400", mem_read, mem_address);
    end
    cyc();
    mem_resp = 1'b1;
    #1;
    n_checks++;
    if ({i_resp, d_resp} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_tie_resp: iresp=%b dresp=%b want 1 0", i_resp, d_resp);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_stray_resp();
    idle_inputs();
    cyc();
    mem_resp = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0000) begin
        n_fail++;
        $display("FAIL stray%0d: iresp/dresp/rd/wr=%b want 0000", k, {i_resp, d_resp, mem_read, mem_write});
      end
      cyc();
    end
    mem_resp = 1'b0;
    i_read = 1'b1;
    i_address = 32'h0000_0080;
    cyc();
    n_checks++;
    if ({mem_read, mem_address} !== {1'b1, 32'h80}) begin
      n_fail++;
      $display("FAIL stray_then_grant: rd=%b addr=%h want 1 80", mem_read, mem_address);
    end
    cyc();
    mem_resp = 1'b1;
    #1;
    n_checks++;
    if (i_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_then_resp: iresp=%b want 1", i_resp);
    end
    cyc();
    idle_inputs();
  endtask

  // Requesters hold until their completion; the model predicts grant order and routing
  task automatic test_random();
    logic              i_pend, d_pend, i_done, d_done;
    logic              serving, first, cur_d, last_d, exp_wr, exp_i, exp_dr;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata;
    int                n_i, n_d;
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; i_done = 1'b0; d_done = 1'b0;
    serving = 1'b0; first = 1'b0; cur_d = 1'b0; last_d = 1'b1; exp_wr = 1'b0;
    exp_addr = '0; exp_wdata = '0; n_i = 0; n_d = 0;
    for (int c = 0; c < 1500; c++) begin
      if (i_done) begin
        i_pend = 1'b0; i_read = 1'b0;
      end else if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_read = 1'b1; i_address = $urandom;
      end
      if (d_done) begin
        d_pend = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end else if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        case ($urandom_range(0, 2))
          0:       begin d_read = 1'b1; d_write = 1'b0; end
          1:       begin d_read = 1'b0; d_write = 1'b1; end
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_address = $urandom;
        d_wdata = rand_line();
      end
      i_done = 1'b0;
      d_done = 1'b0;
      mem_resp = serving ? (!first && $urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = rand_line();
      #1;
      n_checks++;
      if (serving) begin
        if ({mem_read, mem_write, mem_address} !== {~exp_wr, exp_wr, exp_addr} ||
            (exp_wr && mem_wdata !== exp_wdata)) begin
          n_fail++;
          $display("FAIL rand_mem c%0d: rd=%b wr=%b addr=%h want %b %b %h",
                   c, mem_read, mem_write, mem_address, ~exp_wr, exp_wr, exp_addr);
        end
      end else if (mem_read | mem_write) begin
        n_fail++;
        $display("FAIL rand_idle c%0d: rd=%b wr=%b want 0 0", c, mem_read, mem_write);
      end
      exp_i  = serving && mem_resp && !cur_d;
      exp_dr = serving && mem_resp && cur_d;
      n_checks++;
      if ({i_resp, d_resp} !== {exp_i, exp_dr} || (exp_i && i_rdata !== mem_rdata) ||
          (exp_dr && d_rdata !== mem_rdata)) begin
        n_fail++;
        $display("FAIL rand_resp c%0d: iresp=%b dresp=%b want %b %b", c, i_resp, d_resp, exp_i, exp_dr);
      end
      i_done = exp_i;
      d_done = exp_dr;
      first = 1'b0;
      if (serving) begin
        if (mem_resp) serving = 1'b0;
      end else if (i_pend || d_pend) begin
        cur_d = d_pend && (!i_pend || !last_d);
        last_d = cur_d;
        serving = 1'b1;
        first = 1'b1;
        exp_addr = cur_d ? d_address : i_address;
        exp_wr = cur_d && d_write;
        exp_wdata = d_wdata;
        if (cur_d) n_d++; else n_i++;
      end
      cyc();
    end
    idle_inputs();
    n_checks++;
    if (n_i < 20 || n_d < 20) begin
      n_fail++;
      $display("FAIL rand_coverage: i_grants=%0d d_grants=%0d want >=20 each", n_i, n_d);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    test_reset();
    test_single_fetch();
    test_tie_alternate();
    test_data_write();
    test_rw_collision();
    test_reset_mid();
    test_stray_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
